// File: rtl/receptor_medida_7e1_pkg.sv
// Shared constants and bit-level FSM encodings for the 7E1 measurement receiver.
package receptor_medida_7e1_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;

    localparam logic [6:0] ASCII_HASH = 7'h23;
    localparam logic [6:0] ASCII_ZERO = 7'h30;
    localparam logic [6:0] ASCII_NINE = 7'h39;

    // Encodings are exported on db_estado, so they are fixed explicitly.
    typedef enum logic [3:0] {
        ESPERA   = 4'd0,
        CONFIRMA = 4'd1,
        RECEBE   = 4'd2,
        PARADA   = 4'd3,
        ENTREGA  = 4'd4
    } estado_t;

    function automatic logic eh_digito(input logic [6:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/receptor_medida_7e1_rx.sv
// Character-level 7E1 receiver: start detection, mid-bit sampling, parity and stop checks.
module rx_serial_7E1
    import receptor_medida_7e1_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [6:0] dado,
    output logic       pronto_rx,
    output logic       erro_paridade,
    output logic       erro_quadro,
    output logic [3:0] estado_dbg
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FIM_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FIM_MEIO = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync_a;
    logic          sync_b;
    logic          linha_ant;
    estado_t       estado;
    estado_t       proximo;
    logic [CW-1:0] cnt;
    logic [2:0]    n_bits;
    logic [7:0]    desloc;
    logic          parada_ok;
    logic          borda_descida;
    logic          fim_meio;
    logic          fim_bit;
    logic          entrega;
    logic          paridade_ok;

    // Idle-high presets keep a reset release from looking like a start edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a    <= 1'b1;
            sync_b    <= 1'b1;
            linha_ant <= 1'b1;
        end else begin
            sync_a    <= entrada_serial;
            sync_b    <= sync_a;
            linha_ant <= sync_b;
        end
    end

    assign borda_descida = linha_ant & ~sync_b;
    assign fim_meio      = (cnt == FIM_MEIO);
    assign fim_bit       = (cnt == FIM_BIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= ESPERA;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            ESPERA:   if (borda_descida) proximo = CONFIRMA;
            CONFIRMA: if (fim_meio) proximo = sync_b ? ESPERA : RECEBE;
            RECEBE:   if (fim_bit && (n_bits == 3'd7)) proximo = PARADA;
            PARADA:   if (fim_bit) proximo = ENTREGA;
            ENTREGA:  proximo = ESPERA;
            default:  proximo = ESPERA;
        endcase
    end

    // After the half-bit confirm, every later sample lands one full bit apart.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            n_bits    <= 3'd0;
            desloc    <= 8'h00;
            parada_ok <= 1'b0;
        end else begin
            case (estado)
                CONFIRMA:       cnt <= fim_meio ? '0 : cnt + 1'b1;
                RECEBE, PARADA: cnt <= fim_bit ? '0 : cnt + 1'b1;
                default:        cnt <= '0;
            endcase

            if (estado == CONFIRMA) begin
                n_bits <= 3'd0;
            end else if ((estado == RECEBE) && fim_bit) begin
                n_bits <= n_bits + 3'd1;
                desloc <= {sync_b, desloc[7:1]};
            end

            if ((estado == PARADA) && fim_bit) begin
                parada_ok <= sync_b;
            end
        end
    end

    assign entrega     = (estado == ENTREGA);
    assign paridade_ok = ~(^desloc);
    assign dado        = desloc[6:0];
    assign estado_dbg  = estado;

    // A bad stop bit masks any parity verdict for the same character.
    assign pronto_rx     = entrega & parada_ok & paridade_ok;
    assign erro_quadro   = entrega & ~parada_ok;
    assign erro_paridade = entrega & parada_ok & ~paridade_ok;

endmodule

// File: rtl/receptor_medida_7e1.sv
// Assembles '<unidade><dezena><centena>#' frames from the serial receiver into a BCD measurement.
module receptor_medida_7e1
    import receptor_medida_7e1_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro_paridade,
    output logic        erro_quadro,
    output logic        ocupado,
    output logic [3:0]  db_estado
);

    logic [6:0] dado;
    logic       pronto_rx;
    logic       rx_erro_paridade;
    logic       rx_erro_quadro;
    logic [3:0] estado_rx;
    logic [1:0] indice;
    logic       resync;
    logic [3:0] unidade;
    logic [3:0] dezena;
    logic [3:0] centena;
    logic       pronto_q;
    logic       digito;
    logic       hash;
    logic       erro_seq;

    rx_serial_7E1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock         (clock),
        .reset         (reset),
        .entrada_serial(entrada_serial),
        .dado          (dado),
        .pronto_rx     (pronto_rx),
        .erro_paridade (rx_erro_paridade),
        .erro_quadro   (rx_erro_quadro),
        .estado_dbg    (estado_rx)
    );

    assign digito = eh_digito(dado);
    assign hash   = (dado == ASCII_HASH);

    always_comb begin
        erro_seq = 1'b0;
        if (pronto_rx && !resync) begin
            if (indice == 2'd3) begin
                erro_seq = !hash;
            end else begin
                erro_seq = !digito;
            end
        end
    end

    // Any fault drops into resync; only a clean '#' there realigns the index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            indice   <= 2'd0;
            resync   <= 1'b0;
            unidade  <= 4'h0;
            dezena   <= 4'h0;
            centena  <= 4'h0;
            medida   <= 12'h000;
            pronto_q <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            if (rx_erro_paridade || rx_erro_quadro || erro_seq) begin
                resync <= 1'b1;
                indice <= 2'd0;
            end else if (pronto_rx) begin
                if (resync) begin
                    if (hash) begin
                        resync <= 1'b0;
                        indice <= 2'd0;
                    end
                end else begin
                    case (indice)
                        2'd0: begin
                            unidade <= dado[3:0];
                            indice  <= 2'd1;
                        end
                        2'd1: begin
                            dezena <= dado[3:0];
                            indice <= 2'd2;
                        end
                        2'd2: begin
                            centena <= dado[3:0];
                            indice  <= 2'd3;
                        end
                        default: begin
                            medida   <= {centena, dezena, unidade};
                            pronto_q <= 1'b1;
                            indice   <= 2'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign pronto        = pronto_q;
    assign erro_paridade = rx_erro_paridade;
    assign erro_quadro   = rx_erro_quadro | erro_seq;
    assign ocupado       = (estado_rx != ESPERA);
    assign db_estado     = estado_rx;

endmodule

// File: doc/receptor_medida_7e1.md
RECEPTOR_MEDIDA_7E1 -- requirements
Module: receptor_medida_7e1

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clocks per serial bit (50 MHz, 115200 baud).
REQ-002 clock  input  1  single system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; clears all state immediately.
REQ-004 entrada_serial  input  1  7E1 line, idle high; synchronised internally by 2 flip-flops.
REQ-005 medida  output  12  last accepted BCD measurement {centena, dezena, unidade}.
REQ-006 pronto  output  1  one-cycle pulse when medida updates.
REQ-007 erro_paridade  output  1  one-cycle pulse on a character with bad even parity.
REQ-008 erro_quadro  output  1  one-cycle pulse on a bad stop bit or a bad frame sequence.
REQ-009 ocupado  output  1  high while a character is being received.
REQ-010 db_estado  output  4  current state of the bit-level FSM, for debug.

Function
REQ-011 Character format: 1 start bit (low), 7 data bits LSB first, 1 even-parity bit, 1 stop bit (high).
REQ-012 Bit FSM states and transitions:
- ESPERA: idle.
- ESPERA -> CONFIRMA on a synchronised falling edge.
- CONFIRMA waits CLKS_PER_BIT/2 clocks and resamples.
- CONFIRMA -> ESPERA if the line is high (glitch); no error is flagged.
- CONFIRMA -> RECEBE otherwise.
REQ-013 RECEBE samples 8 bits (7 data + parity), each exactly CLKS_PER_BIT clocks after the previous sample (mid-bit), then goes to PARADA.
REQ-014 PARADA samples the stop bit mid-bit, goes to ENTREGA for 1 cycle, then returns to ESPERA.
REQ-015 Parity check: XOR of the 7 data bits and the parity bit SHALL be 0; otherwise erro_paridade pulses in ENTREGA and the character is discarded.
REQ-016 Stop check: a stop sample of 0 pulses erro_quadro in ENTREGA and discards the character; parity is not reported for that character.
REQ-017 Frame order: index 0 = unidade, 1 = dezena, 2 = centena, 3 = '#' (7'h23).
REQ-018 Digits are valid only in the range 7'h30..7'h39; the low nibble is latched into a shadow register for that index.
REQ-019 A valid '#' at index 3 copies the shadow registers to medida and pulses pronto on the cycle after ENTREGA; the index then returns to 0.
REQ-020 Sequence errors each pulse erro_quadro and enter RESYNC:
- non-digit at index 0..2;
- '#' at index 0..2;
- non-'#' at index 3.
REQ-021 Any parity or stop error also enters RESYNC.
REQ-022 RESYNC discards characters until a valid '#' is received, then sets the index to 0; no pronto is produced by that '#'.
REQ-023 medida holds its value across errors and RESYNC; only REQ-019 changes it.
REQ-024 ocupado is high in CONFIRMA, RECEBE, PARADA and ENTREGA; low otherwise.
REQ-025 pronto, erro_paridade and erro_quadro are never high in the same cycle.

Reset
REQ-026 While reset = 0:
- medida = 12'h000; pronto, erro_paridade, erro_quadro and ocupado = 0;
- bit FSM = ESPERA; index = 0; not in RESYNC;
- synchronisers preset to 1.
REQ-027 Reset asserted mid-character abandons the character; after release, reception restarts at the next falling edge with index 0.

Structure
REQ-028 A shared package holds:
- CLKS_PER_BIT default;
- ASCII_HASH = 7'h23, ASCII_ZERO = 7'h30, ASCII_NINE = 7'h39;
- bit FSM state encodings (4-bit, matching db_estado).
REQ-029 One sub-module, rx_serial_7E1, implements REQ-011..016 and outputs a 7-bit dado, a pronto_rx pulse, erro_paridade and erro_quadro.
REQ-030 The top level contains the frame index, RESYNC flag, shadow registers and medida register.

Verification
REQ-031 Send '3','2','1','#' -> medida = 12'h123 with one pronto pulse 1 cycle after the '#' ENTREGA; no error pulses.
REQ-032 Send '5','#' then '7','8','9','#':
- '#' at index 1 -> erro_quadro pulse, medida unchanged;
- the next '#' resyncs with no pronto;
- a further '1','2','3','#' -> medida = 12'h321.
REQ-033 Send '4' with parity flipped, then '#', '6','5','4','#' -> erro_paridade once, then medida = 12'h456.
REQ-034 Hold the line low for 100 clocks then high -> no error and no pronto; FSM back in ESPERA; ocupado high only during the glitch.
REQ-035 Send '9' with stop bit = 0 -> erro_quadro pulse, RESYNC entered, medida unchanged.
REQ-036 Assert reset during bit 4 of dezena after a prior medida = 12'h777 -> medida = 12'h000; a following '1','0','0','#' -> medida = 12'h001.
